// File: rtl/demux_sched.sv
`default_nettype none
// ============================================================================
// Module      : demux_sched
// Description : Sequencing controller for a 1-to-4 demultiplexer. Grants one
//               output channel per burst (round-robin or fixed), moves words
//               through a single registered output slot, and releases the
//               grant after BURST words or when the producer goes quiet.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_sched #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       fix_sel,
    input  logic [3:0]       out_ready,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic             busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       last_q,  last_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic             full_q,  full_d;
    logic [WIDTH-1:0] data_q,  data_d;

    logic             w_drain;
    logic             w_accept;
    logic             w_rr_found;
    logic [1:0]       w_rr_pick;
    logic [1:0]       w_rr_cand;

    // Round-robin pick: first ready channel after the last one served
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = last_q;
        w_rr_cand  = last_q;
        for (int i = 1; i <= 4; i++) begin
            w_rr_cand = last_q + 2'(i);
            if (!w_rr_found && out_ready[w_rr_cand]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_rr_cand;
            end
        end
    end

    // Handshake outputs depend only on registered state and out_ready
    always_comb begin
        w_drain   = full_q & out_ready[sel_q];
        in_ready  = (state_q == c_GRANT) & (~full_q | out_ready[sel_q]);
        w_accept  = in_valid & in_ready;
        out_valid = 4'b0000;
        if (full_q) begin
            out_valid[sel_q] = 1'b1;
        end
        busy      = (state_q != c_IDLE);
        sel       = sel_q;
        out_data  = data_q;
    end

    // Next-state logic for grant sequencing and the output slot
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        data_d  = data_q;
        case (state_q)
            c_IDLE: begin
                if (in_valid) begin
                    if (mode) begin
                        sel_d   = fix_sel;
                        cnt_d   = 8'd0;
                        state_d = c_GRANT;
                    end else if (w_rr_found) begin
                        sel_d   = w_rr_pick;
                        cnt_d   = 8'd0;
                        state_d = c_GRANT;
                    end
                end
            end
            c_GRANT: begin
                if (w_accept) begin
                    data_d = in_data;
                    full_d = 1'b1;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'(BURST - 1)) begin
                        state_d = c_DRAIN;
                    end
                end else begin
                    if (w_drain) begin
                        full_d = 1'b0;
                    end
                    // Producer went quiet and the slot is (or becomes) empty
                    if (!in_valid && (!full_q || w_drain)) begin
                        state_d = c_IDLE;
                        last_d  = sel_q;
                    end
                end
            end
            c_DRAIN: begin
                if (!full_q || w_drain) begin
                    state_d = c_IDLE;
                    last_d  = sel_q;
                    full_d  = 1'b0;
                end
            end
            default: begin
                state_d = c_IDLE;
                full_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any held word at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 8'd0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_sched
// Description : Self-checking bench for demux_sched. A transaction-level model
//               (grant owner, burst word count, held-word queue) predicts the
//               handshake outputs; accepted words are queued with their
//               expected channel and matched against channel transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_sched;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             mode;
    logic [1:0]       fix_sel;
    logic [3:0]       out_ready;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       sel;
    logic             busy;

    demux_sched #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .fix_sel   (fix_sel),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected channel and word for every accepted input
    logic [1:0]       sb_ch[$];
    logic [WIDTH-1:0] sb_d[$];
    int               got_ch[256];

    // Reference model state
    int               m_grant = -1;
    int               m_last  = 3;
    int               m_words = 0;
    bit               m_done  = 1'b0;
    logic [WIDTH-1:0] m_hold[$];

    // Model: check outputs before each edge, then advance at the edge
    initial begin
        bit               e_busy, e_full, e_rdy, s_acc, s_valid, s_mode;
        bit               drained, was_empty, was_done, released;
        logic [3:0]       e_valid, s_ready;
        logic [1:0]       s_fix;
        logic [WIDTH-1:0] s_data;
        int               pick;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                check("rst_in_ready", 32'(in_ready), 32'd0);
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_sel", 32'(sel), 32'd0);
                check("rst_out_data", 32'(out_data), 32'd0);
                m_grant = -1;
                m_last  = 3;
                m_words = 0;
                m_done  = 1'b0;
                m_hold.delete();
                sb_ch.delete();
                sb_d.delete();
                @(posedge clk);
                continue;
            end
            e_busy  = (m_grant >= 0);
            e_full  = (m_hold.size() > 0);
            e_rdy   = e_busy && !m_done && (!e_full || out_ready[m_grant[1:0]]);
            e_valid = e_full ? 4'(1 << m_grant) : 4'b0000;
            check("in_ready", 32'(in_ready), 32'(e_rdy));
            check("busy", 32'(busy), 32'(e_busy));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            if (e_busy) check("sel", 32'(sel), 32'(m_grant));
            if (e_full) check("out_data", 32'(out_data), 32'(m_hold[0]));
            s_valid = in_valid;
            s_data  = in_data;
            s_mode  = mode;
            s_fix   = fix_sel;
            s_ready = out_ready;
            s_acc   = s_valid && e_rdy;
            if (s_acc) begin
                sb_ch.push_back(m_grant[1:0]);
                sb_d.push_back(s_data);
            end
            @(posedge clk);
            if (!rst_n) continue;
            if (m_grant < 0) begin
                if (s_valid) begin
                    pick = -1;
                    if (s_mode) pick = int'(s_fix);
                    else begin
                        for (int k = 1; k <= 4; k++) begin
                            if (pick < 0 && s_ready[(m_last + k) % 4]) pick = (m_last + k) % 4;
                        end
                    end
                    if (pick >= 0) begin
                        m_grant = pick;
                        m_words = 0;
                        m_done  = 1'b0;
                    end
                end
            end else begin
                was_empty = (m_hold.size() == 0);
                was_done  = m_done;
                drained   = !was_empty && s_ready[m_grant[1:0]];
                if (drained) void'(m_hold.pop_front());
                if (s_acc) begin
                    m_hold.push_back(s_data);
                    m_words++;
                    if (m_words == BURST) m_done = 1'b1;
                end
                released = !s_acc && (was_empty || drained) && (was_done || !s_valid);
                if (released) begin
                    m_last  = m_grant;
                    m_grant = -1;
                    m_hold.delete();
                end
            end
        end
    end

    // Monitor: match each channel transfer against the scoreboard
    initial begin
        int               ch;
        logic [1:0]       e_ch;
        logic [WIDTH-1:0] e_d;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n || (out_valid & out_ready) == 4'b0000) continue;
            ch = 0;
            for (int k = 0; k < 4; k++) if (out_valid[k] && out_ready[k]) ch = k;
            got_ch[out_data] = ch;
            if (sb_ch.size() == 0) begin
                check("sb_unexpected_xfer", 32'(out_data), 32'hFFFF);
            end else begin
                e_ch = sb_ch.pop_front();
                e_d  = sb_d.pop_front();
                check("xfer_channel", 32'(ch), 32'(e_ch));
                check("xfer_data", 32'(out_data), 32'(e_d));
            end
        end
    end

    // Present one word and hold it until accepted (bounded)
    task automatic send(input logic [WIDTH-1:0] w);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            #4;
            ok = in_ready;
            @(negedge clk);
        end
        check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        for (int i = 0; i < 256; i++) got_ch[i] = -1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        fix_sel   = 2'd0;
        out_ready = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round-robin stream: two bursts on channels 0 then 1
        for (int w = 8'h10; w <= 8'h17; w++) send(8'(w));
        idle_cycles(8);
        for (int w = 8'h10; w <= 8'h17; w++)
            check("rr_stream_channel", 32'(got_ch[w]), (w < 8'h14) ? 32'd0 : 32'd1);

        // Fixed mode onto a stalled channel, then backpressure hold
        mode      = 1'b1;
        fix_sel   = 2'd2;
        out_ready = 4'b1011;
        send(8'h5A);
        in_valid = 1'b0;
        mode     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            check("hold_valid", 32'(out_valid), 32'h4);
            check("hold_data", 32'(out_data), 32'h5A);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 4'hF;
        idle_cycles(6);
        check("fixed_channel", 32'(got_ch[8'h5A]), 32'd2);

        // Reset with a word held in the output slot
        mode      = 1'b1;
        fix_sel   = 2'd3;
        out_ready = 4'b0000;
        send(8'h33);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        out_ready = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 1'b0;
        send(8'h77);
        idle_cycles(8);
        check("no_deliver_after_rst", 32'(got_ch[8'h33]), 32'hFFFF_FFFF);
        check("first_grant_after_rst", 32'(got_ch[8'h77]), 32'd0);

        // Randomized traffic, including early release and mode toggling
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            fix_sel   = 2'($urandom);
            out_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom | $urandom);
            @(negedge clk);
        end
        out_ready = 4'hF;
        idle_cycles(20);
        check("sb_drained", 32'(sb_ch.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
